qsys_serial_responder: RTL

- Peripheral-side end of the three-wire Qsys serial link (sdo/sle/srdy/sdi plus forwarded clock).
- Deserialises a 65-bit command frame, performs one Avalon-MM read or write on the local register bus, then returns 32 bits of data over sdi, framed by srdy.
- Sits in the peripheral FPGA/island, clocked by the forwarded link clock.

---
 rtl/qsys_serial_pkg.sv | 32 +++
 rtl/qsys_serial_shifter.sv | 35 +++
 rtl/qsys_serial_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/qsys_serial_pkg.sv
// Shared definitions for both ends of the Qsys serial link: frame layout,
// counter widths and the responder state encoding.
package qsys_serial_pkg;

   localparam int FRAME_BITS   = 65;
   localparam int RESP_BITS    = 32;
   localparam int ADDR_FIELD_W = 32;

   localparam int RW_BIT   = 64;
   localparam int ADDR_MSB = 63;
   localparam int ADDR_LSB = 32;
   localparam int DATA_MSB = 31;

   // Bit counters are wide enough to saturate well past a full frame.
   localparam int                CNT_W     = 7;
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  FRAME_CNT = 7'(FRAME_BITS);
   localparam logic [CNT_W-1:0]  RESP_LAST = 7'(RESP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_IN,
      ACCESS,
      GAP,
      RESP
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/qsys_serial_shifter.sv
// Serial-in/parallel-out and parallel-in/serial-out shift register (MSB first)
// with a saturating bit counter; load wins over shift, restart counts from 1.
module qsys_serial_shifter
   import qsys_serial_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_dat,
   input  logic             shift,
   input  logic             restart,
   input  logic             sin,
   output logic [WIDTH-1:0] dat,
   output logic             sout,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dat <= '0;
         cnt <= '0;
      end else if (load) begin
         dat <= load_dat;
         cnt <= '0;
      end else if (shift) begin
         dat <= {dat[WIDTH-2:0], sin};
         cnt <= restart ? CNT_W'(1) : sat_inc(cnt);
      end
   end

   assign sout = dat[WIDTH-1];

endmodule

// File: rtl/qsys_serial_responder.sv
// Peripheral end of the Qsys serial link: receives a 65-bit command, runs one
// Avalon-MM access (stalls on waitrequest), then returns 32 bits framed by srdy.
module qsys_serial_responder
   import qsys_serial_pkg::*;
#(
   parameter int address_size = 8,
   parameter int resp_idle    = 0
) (
   input  logic                    csi_MCLK_clk,
   input  logic                    rsi_MRST_reset_n,
   input  logic                    sle,
   input  logic                    sdo,
   output logic                    sdi,
   output logic                    srdy,
   output logic [address_size-1:0] avm_address,
   output logic [31:0]             avm_writedata,
   output logic                    avm_write,
   output logic                    avm_read,
   input  logic [31:0]             avm_readdata,
   input  logic                    avm_waitrequest,
   output logic                    frame_err
);

   localparam logic [3:0] GAP_CYCLES = 4'(resp_idle);

   state_t                 state, state_nxt;
   logic [FRAME_BITS-1:0]  rx_dat;
   logic [CNT_W-1:0]       rx_cnt, tx_cnt;
   logic                   rx_shift, rx_restart;
   logic                   tx_load, tx_shift, tx_sout;
   logic [RESP_BITS-1:0]   tx_load_dat;
   logic [3:0]             gap_cnt;
   logic                   sle_seen;
   logic                   bus_start, bus_done, short_frame, stray_sle;
   logic                   rx_sout_unused;
   logic [RESP_BITS-1:0]   tx_dat_unused;

   qsys_serial_shifter #(.WIDTH(FRAME_BITS)) u_rx (
      .clk      (csi_MCLK_clk),
      .rst_n    (rsi_MRST_reset_n),
      .load     (1'b0),
      .load_dat ('0),
      .shift    (rx_shift),
      .restart  (rx_restart),
      .sin      (sdo),
      .dat      (rx_dat),
      .sout     (rx_sout_unused),
      .cnt      (rx_cnt)
   );

   qsys_serial_shifter #(.WIDTH(RESP_BITS)) u_tx (
      .clk      (csi_MCLK_clk),
      .rst_n    (rsi_MRST_reset_n),
      .load     (tx_load),
      .load_dat (tx_load_dat),
      .shift    (tx_shift),
      .restart  (1'b0),
      .sin      (1'b0),
      .dat      (tx_dat_unused),
      .sout     (tx_sout),
      .cnt      (tx_cnt)
   );

   if (address_size < ADDR_FIELD_W) begin : g_addr_trim
      logic addr_hi_unused;
      assign addr_hi_unused = ^rx_dat[ADDR_MSB:ADDR_LSB+address_size];
   end

   always_comb begin
      state_nxt   = state;
      rx_shift    = 1'b0;
      rx_restart  = 1'b0;
      tx_load     = 1'b0;
      tx_load_dat = '0;
      tx_shift    = 1'b0;
      bus_start   = 1'b0;
      bus_done    = 1'b0;
      short_frame = 1'b0;
      unique case (state)
         IDLE: begin
            if (sle) begin
               rx_shift   = 1'b1;
               rx_restart = 1'b1;
               state_nxt  = SHIFT_IN;
            end
         end
         SHIFT_IN: begin
            if (sle) begin
               rx_shift = 1'b1;
            end else if (rx_cnt == FRAME_CNT) begin
               bus_start = 1'b1;
               state_nxt = ACCESS;
            end else begin
               // Malformed frame still gets a full (all-zero) response so the
               // master's framing stays in step.
               short_frame = 1'b1;
               tx_load     = 1'b1;
               state_nxt   = RESP;
            end
         end
         ACCESS: begin
            if (!avm_waitrequest) begin
               bus_done    = 1'b1;
               tx_load     = 1'b1;
               tx_load_dat = avm_read ? avm_readdata : avm_writedata;
               state_nxt   = GAP;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_CYCLES) state_nxt = RESP;
         end
         RESP: begin
            tx_shift = 1'b1;
            if (tx_cnt == RESP_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign stray_sle = sle && !sle_seen &&
                      ((state == ACCESS) || (state == GAP) || (state == RESP));
   assign srdy      = (state == RESP);

   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         state         <= IDLE;
         sdi           <= 1'b0;
         frame_err     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         avm_write     <= 1'b0;
         avm_read      <= 1'b0;
         gap_cnt       <= '0;
         sle_seen      <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_err <= short_frame || stray_sle;
         // sdi trails srdy by one cycle so each bit is stable on the edge after
         // its srdy-high cycle.
         sdi       <= (state == RESP) && tx_sout;

         if (bus_start) begin
            avm_address   <= rx_dat[ADDR_LSB +: address_size];
            avm_writedata <= rx_dat[DATA_MSB:0];
            avm_write     <= rx_dat[RW_BIT];
            avm_read      <= !rx_dat[RW_BIT];
         end else if (bus_done) begin
            avm_write <= 1'b0;
            avm_read  <= 1'b0;
         end

         gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;

         if (state == IDLE)   sle_seen <= 1'b0;
         else if (stray_sle)  sle_seen <= 1'b1;
      end
   end

endmodule
